i_prefetch_buffer: RTL and testbench
====================================

Name: i_prefetch_buffer

Overview:
- Single-line next-line stream buffer between the I_cache memory port and the instruction memory.
- A demand line fill (cache miss) is forwarded to memory. The block then prefetches line addr+1 into a one-entry buffer, so that a sequential next miss is served in one cycle.
- Writes pass straight through; any buffered or in-flight copy of the written line is invalidated.
- Cache-side and memory-side ports use the existing 28-bit line address / 128-bit data / level-request, one-cycle ready-pulse protocol.

Parameters:
- PREFETCH_EN, 1, 1 = issue next-line prefetch after every demand read; 0 = pure registered pass-through, buffer never valid.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, all logic on posedge
- proc_reset  in  1  synchronous active-high reset
- c_read  in  1  cache line-read request, held until c_ready
- c_write  in  1  cache line-write request, held until c_ready
- c_addr  in  28  cache line address
- c_wdata  in  128  cache write-back line
- c_rdata  out  128  line returned to cache, valid when c_ready=1
- c_ready  out  1  one-cycle completion pulse to cache
- mem_read  out  1  memory read request (registered)
- mem_write  out  1  memory write request (registered)
- mem_addr  out  28  memory line address (registered)
- mem_wdata  out  128  memory write line (registered)
- mem_rdata  in  128  memory read line, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse
- hit_cnt  out  CNT_W  buffer hits, saturating
- miss_cnt  out  CNT_W  demand reads sent to memory, saturating

Behaviour:
- Reset values:
  - state IDLE; buf_valid=0; buf_addr=0; buf_data=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; c_ready=0, c_rdata=0.
  - Both counters 0.
- Reset has priority over everything. A reset mid-transaction abandons it; a stale mem_ready arriving afterwards in IDLE is ignored.
- States: IDLE, HIT, DEMAND, WRITE, PREF.
- IDLE, evaluated in priority order:
  - c_write: latch addr/wdata, mem_write=1 next cycle, go WRITE. If c_addr==buf_addr, clear buf_valid.
  - c_read with buf_valid and c_addr==buf_addr: go HIT, increment hit_cnt.
  - c_read otherwise: mem_read=1, mem_addr=c_addr next cycle, go DEMAND, increment miss_cnt.
- HIT:
  - c_ready=1 and c_rdata=buf_data for exactly one cycle. Latency is 1 cycle from the request being sampled.
  - Clear buf_valid, set pf_addr=buf_addr+1.
  - Go PREF if PREFETCH_EN, else IDLE.
- DEMAND:
  - Hold mem_read until mem_ready. On mem_ready, c_ready=mem_ready and c_rdata=mem_rdata combinationally in the same cycle.
  - Drop mem_read the next cycle, set pf_addr=addr+1.
  - Go PREF if PREFETCH_EN, else IDLE.
- WRITE:
  - Hold mem_write until mem_ready. c_ready=mem_ready, then go IDLE.
- PREF:
  - mem_read=1, mem_addr=pf_addr until mem_ready. Cache requests arriving meanwhile wait; c_ready stays 0. Memory transactions are never aborted.
  - On mem_ready: buf_data=mem_rdata, buf_addr=pf_addr, buf_valid=1 unless pf_kill is set. Go IDLE; the waiting request is evaluated there next cycle.
  - A c_write seen during PREF whose address equals pf_addr sets pf_kill. The write itself is served after PREF completes.
- Address arithmetic: pf_addr is 28-bit modulo, so 28'hFFFFFFF+1 = 28'h0000000.
- Cache handshake: the cache drops its request the cycle after c_ready. The block does not sample c_read/c_write in the cycle c_ready is high.
- Counters saturate at all-ones and never wrap.
- Throughput: at most one outstanding memory transaction. No request in IDLE means the memory-side outputs stay deasserted.

Decomposition:
- Shared package:
  - state encoding constants IDLE/HIT/DEMAND/WRITE/PREF
  - LINE_AW=28, LINE_DW=128
- Sub-module: pf_sat_counter (CNT_W, inc, proc_reset), instantiated twice for hit_cnt and miss_cnt. The FSM and buffer stay in the top module.

Test Plan:
- Cold miss, c_read addr 28'h10, memory ready after 3 cycles with data D0 -> c_ready pulse carries D0 in the mem_ready cycle. Then mem_read with mem_addr 28'h11; the buffer holds D1 after the next mem_ready; miss_cnt=1.
- Sequential hit, c_read 28'h11 after the prefetch completes -> c_ready exactly 1 cycle later with D1, no memory access for 28'h11, hit_cnt=1. A prefetch of 28'h12 starts 1 cycle after c_ready.
- Request during prefetch, c_read 28'h12 issued while the 28'h12 prefetch is pending -> held until the prefetch's mem_ready. Then a HIT response; total latency = remaining prefetch time + 2 cycles.
- Write invalidation:
  - c_write 28'h13 while buf_addr=28'h13 valid -> buf_valid=0, the write reaches memory with the exact wdata, c_ready on mem_ready.
  - A following c_read 28'h13 -> goes to DEMAND, not HIT.
  - Same check with the write arriving during PREF to 28'h13 -> pf_kill set, buffer left invalid.
- Wrap-around, c_read 28'hFFFFFFF miss -> prefetch mem_addr=28'h0000000; a later c_read 28'h0 -> HIT.
- Reset mid-DEMAND, proc_reset for one cycle while mem_read=1 -> all outputs zero next cycle. A stale mem_ready afterwards produces no c_ready, and the buffer stays invalid. Counter saturation is checked by forcing CNT_W=2 and performing 5 misses -> miss_cnt=3.

Source files
------------

// File: rtl/i_prefetch_buffer_pkg.sv
// Shared types and constants for the next-line instruction prefetch buffer.
package i_prefetch_buffer_pkg;

  localparam int unsigned LINE_AW = 28;
  localparam int unsigned LINE_DW = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIT    = 3'd1,
    DEMAND = 3'd2,
    WRITE  = 3'd3,
    PREF   = 3'd4
  } pf_state_e;

  // Next sequential line, wrapping modulo the line address space.
  function automatic logic [LINE_AW-1:0] next_line(input logic [LINE_AW-1:0] addr);
    return addr + LINE_AW'(1);
  endfunction

endpackage

// File: rtl/pf_sat_counter.sv
// Saturating up-counter used for the buffer hit/miss statistics.
module pf_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/i_prefetch_buffer.sv
// One-entry next-line stream buffer between the I-cache memory port and memory.
module i_prefetch_buffer
  import i_prefetch_buffer_pkg::*;
#(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               c_read,
  input  logic               c_write,
  input  logic [LINE_AW-1:0] c_addr,
  input  logic [LINE_DW-1:0] c_wdata,
  output logic [LINE_DW-1:0] c_rdata,
  output logic               c_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [LINE_AW-1:0] mem_addr,
  output logic [LINE_DW-1:0] mem_wdata,
  input  logic [LINE_DW-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  pf_state_e          state_q;
  logic               buf_valid_q;
  logic [LINE_AW-1:0] buf_addr_q;
  logic [LINE_DW-1:0] buf_data_q;
  logic [LINE_AW-1:0] pf_addr_q;
  logic               pf_kill_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [LINE_AW-1:0] mem_addr_q;
  logic [LINE_DW-1:0] mem_wdata_q;

  logic buf_hit;
  logic hit_inc;
  logic miss_inc;
  logic pf_wr_match;

  assign buf_hit     = buf_valid_q && (c_addr == buf_addr_q);
  assign hit_inc     = (state_q == IDLE) && !c_write && c_read && buf_hit;
  assign miss_inc    = (state_q == IDLE) && !c_write && c_read && !buf_hit;
  // A write to the line being prefetched makes the incoming copy stale.
  assign pf_wr_match = c_write && (c_addr == pf_addr_q);

  // Cache response: buffered line in HIT, memory pass-through in DEMAND/WRITE.
  always_comb begin
    c_ready = 1'b0;
    c_rdata = '0;
    case (state_q)
      HIT: begin
        c_ready = 1'b1;
        c_rdata = buf_data_q;
      end
      DEMAND: begin
        if (mem_ready) begin
          c_ready = 1'b1;
          c_rdata = mem_rdata;
        end
      end
      WRITE:   c_ready = mem_ready;
      default: ;
    endcase
  end

  // Control FSM, stream buffer and registered memory-side request.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      pf_addr_q   <= '0;
      pf_kill_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_write) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= c_addr;
            mem_wdata_q <= c_wdata;
            if (c_addr == buf_addr_q) buf_valid_q <= 1'b0;
            state_q <= WRITE;
          end else if (c_read) begin
            if (buf_hit) begin
              state_q <= HIT;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= c_addr;
              state_q    <= DEMAND;
            end
          end
        end
        HIT: begin
          buf_valid_q <= 1'b0;
          pf_addr_q   <= next_line(buf_addr_q);
          pf_kill_q   <= 1'b0;
          if (PREFETCH_EN) begin
            // Raise the prefetch right away; memory is idle during a hit.
            mem_read_q <= 1'b1;
            mem_addr_q <= next_line(buf_addr_q);
            state_q    <= PREF;
          end else begin
            state_q <= IDLE;
          end
        end
        DEMAND: begin
          if (mem_ready) begin
            mem_read_q <= 1'b0;
            pf_addr_q  <= next_line(mem_addr_q);
            pf_kill_q  <= 1'b0;
            state_q    <= PREFETCH_EN ? PREF : IDLE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_write_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        PREF: begin
          // Only a ready pulse against our own raised request completes it.
          if (mem_read_q && mem_ready) begin
            mem_read_q  <= 1'b0;
            buf_data_q  <= mem_rdata;
            buf_addr_q  <= pf_addr_q;
            buf_valid_q <= !(pf_kill_q || pf_wr_match);
            pf_kill_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            mem_read_q <= 1'b1;
            mem_addr_q <= pf_addr_q;
            if (pf_wr_match) pf_kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  pf_sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk       (clk),
    .proc_reset(proc_reset),
    .inc_i     (hit_inc),
    .cnt_o     (hit_cnt)
  );

  pf_sat_counter #(
    .CNT_W(CNT_W)
  ) u_miss_cnt (
    .clk       (clk),
    .proc_reset(proc_reset),
    .inc_i     (miss_inc),
    .cnt_o     (miss_cnt)
  );

endmodule

// File: tb/tb_i_prefetch_buffer.sv
// Self-checking bench for i_prefetch_buffer: directed table, reset corner, random traffic.
module tb_i_prefetch_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset, c_read, c_write;
  logic [27:0]  c_addr;
  logic [127:0] c_wdata, c_rdata, mem_wdata, mem_rdata;
  logic         c_ready, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [15:0]  hit_cnt, miss_cnt;

  // Second instance with 2-bit counters, fed the same stimulus, for saturation.
  logic [127:0] s_c_rdata, s_mem_wdata;
  logic         s_c_ready, s_mem_read, s_mem_write;
  logic [27:0]  s_mem_addr;
  logic [1:0]   s_hit_cnt, s_miss_cnt;

  i_prefetch_buffer dut (
    .clk(clk), .proc_reset(proc_reset), .c_read(c_read), .c_write(c_write),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  i_prefetch_buffer #(.PREFETCH_EN(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .proc_reset(proc_reset), .c_read(c_read), .c_write(c_write),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(s_c_rdata), .c_ready(s_c_ready),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Initial memory contents: a distinct pattern per line address.
  function automatic logic [127:0] init_line(input logic [27:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    return {x ^ 32'hA5A5_5A5A, ~x, x * 32'd3, x + 32'h1234_5678};
  endfunction

  // ---------------- memory responder ----------------
  int           mem_lat = 0;
  logic [127:0] store [logic [27:0]];
  logic [27:0]  rd_log [$];
  int           wr_count = 0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  initial begin : responder
    bit   busy, drop, is_wr;
    int   cnt;
    busy = 0; drop = 0; is_wr = 0; cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (!busy && !drop && (mem_read === 1'b1 || mem_write === 1'b1)) begin
        busy  = 1;
        cnt   = mem_lat;
        is_wr = mem_write;
        if (!mem_write) rd_log.push_back(mem_addr);
      end
      if (busy) begin
        if (cnt == 0) begin
          mem_ready = 1'b1;
          busy = 0;
          drop = 1;
          if (is_wr) begin
            store[mem_addr] = mem_wdata;
            wr_count++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
          end else begin
            mem_rdata = store.exists(mem_addr) ? store[mem_addr] : init_line(mem_addr);
          end
        end else begin
          cnt--;
        end
      end else if (drop && !mem_read && !mem_write) begin
        drop = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected memory image (from the cache's view) and the stream-buffer rule:
  // after any read of line A the buffer holds A+1, until a write to that line.
  logic [127:0] ref_mem [logic [27:0]];
  bit           mdl_valid = 0;
  logic [27:0]  mdl_addr = '0;
  int           mdl_hits = 0;
  int           mdl_misses = 0;

  function automatic logic [127:0] ref_line(input logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           lat;
    int           settle;
    int           exp_lat;  // -1: not checked
    bit           exp_hit;
    bit           chk_pf;
    int           pf_wait;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [27:0] a, logic [127:0] d, int lat, int settle,
                              int exp_lat, bit exp_hit, bit chk_pf, int pf_wait);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.lat = lat; v.settle = settle;
    v.exp_lat = exp_lat; v.exp_hit = exp_hit; v.chk_pf = chk_pf; v.pf_wait = pf_wait;
    return v;
  endfunction

  // Issue one cache transaction at a negedge and check its completion.
  task automatic do_txn(input vec_t v, input bit exp_hit, input bit chk_mem);
    int           waited, log_sz, wc;
    logic [27:0]  nx;
    bit           touched;
    repeat (v.settle) @(negedge clk);
    mem_lat = v.lat;
    log_sz  = rd_log.size();
    wc      = wr_count;
    c_addr  = v.addr;
    c_wdata = v.wr ? v.wdata : {$urandom, $urandom, $urandom, $urandom};
    c_write = v.wr;
    c_read  = !v.wr;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (c_ready !== 1'b1 && waited < 100);
    if (c_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL c_ready_timeout addr %0h: got 0 expected 1", v.addr);
    end else begin
      if (v.exp_lat >= 0) check("latency", 128'(waited), 128'(v.exp_lat));
      if (v.wr) begin
        check("wr_txn_count", 128'(wr_count - wc), 128'(1));
        check("wr_addr", 128'(last_wr_addr), 128'(v.addr));
        check("wr_data", last_wr_data, v.wdata);
        ref_mem[v.addr] = v.wdata;
        if (mdl_addr == v.addr) mdl_valid = 0;
      end else begin
        check("rdata", c_rdata, ref_line(v.addr));
        if (exp_hit) mdl_hits++;
        else mdl_misses++;
        if (exp_hit && chk_mem) begin
          touched = 0;
          for (int j = log_sz; j < rd_log.size(); j++) if (rd_log[j] == v.addr) touched = 1;
          check("hit_no_mem_access", 128'(touched), 128'(0));
        end
        nx = v.addr + 28'd1;
        mdl_valid = 1;
        mdl_addr  = nx;
      end
    end
    c_read  = 1'b0;
    c_write = 1'b0;
    @(negedge clk);
    check("c_ready_single_pulse", 128'(c_ready), 128'(0));
    check("hit_cnt", 128'(hit_cnt), 128'(mdl_hits));
    check("miss_cnt", 128'(miss_cnt), 128'(mdl_misses));
    check("hit_cnt_sat", 128'(s_hit_cnt), 128'(sat3(mdl_hits)));
    check("miss_cnt_sat", 128'(s_miss_cnt), 128'(sat3(mdl_misses)));
  endtask

  localparam logic [127:0] W1 = 128'hDEAD_BEEF_0000_0013_CAFE_0001_1234_5678;
  localparam logic [127:0] W2 = 128'h0BAD_F00D_0000_0014_FACE_0002_8765_4321;
  localparam logic [127:0] W3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl [13];
    vec_t        v;
    int          w;
    logic [27:0] nx;
    bit          eh;

    // wr addr wdata lat settle exp_lat exp_hit chk_pf pf_wait
    tbl[0]  = mk(0, 28'h10,      '0, 3, 0, 4,  0, 1, 1);  // cold miss
    tbl[1]  = mk(0, 28'h11,      '0, 3, 8, 1,  1, 1, 0);  // sequential hit
    tbl[2]  = mk(0, 28'h12,      '0, 3, 0, 5,  1, 0, 0);  // held during prefetch
    tbl[3]  = mk(1, 28'h13,      W1, 2, 8, 3,  0, 0, 0);  // write hits buffered line
    tbl[4]  = mk(0, 28'h13,      '0, 2, 0, 3,  0, 0, 0);  // must go to memory
    tbl[5]  = mk(1, 28'h14,      W2, 2, 0, -1, 0, 0, 0);  // write during prefetch of 14
    tbl[6]  = mk(0, 28'h14,      '0, 1, 6, 2,  0, 0, 0);  // killed prefetch -> miss
    tbl[7]  = mk(0, 28'hFFFFFFF, '0, 1, 6, 2,  0, 1, 1);  // wrap
    tbl[8]  = mk(0, 28'h0,       '0, 1, 6, 1,  1, 0, 0);
    tbl[9]  = mk(0, 28'h1,       '0, 1, 0, 3,  1, 0, 0);
    tbl[10] = mk(0, 28'h50,      '0, 2, 4, 3,  0, 0, 0);
    tbl[11] = mk(1, 28'h51,      W3, 0, 8, 1,  0, 0, 0);
    tbl[12] = mk(0, 28'h51,      '0, 0, 0, 1,  0, 0, 0);

    proc_reset = 1'b1;
    c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_c_ready", 128'(c_ready), 128'(0));
    check("rst_c_rdata", c_rdata, 128'(0));
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_hit_cnt", 128'(hit_cnt), 128'(0));
    check("rst_miss_cnt", 128'(miss_cnt), 128'(0));
    proc_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i], tbl[i].exp_hit, 1'b1);
      if (tbl[i].chk_pf) begin
        w = 0;
        while (mem_read !== 1'b1 && w < 6) begin
          @(negedge clk);
          w++;
        end
        nx = tbl[i].addr + 28'd1;
        check("pf_mem_read", 128'(mem_read), 128'(1));
        check("pf_mem_addr", 128'(mem_addr), 128'(nx));
        check("pf_start_delay", 128'(w), 128'(tbl[i].pf_wait));
      end
    end

    // Reset in the middle of a demand read; the late ready must be ignored.
    repeat (6) @(negedge clk);
    mem_lat = 6;
    c_addr  = 28'h70;
    c_read  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_read", 128'(mem_read), 128'(1));
    proc_reset = 1'b1;
    c_read     = 1'b0;
    @(negedge clk);
    check("mid_rst_c_ready", 128'(c_ready), 128'(0));
    check("mid_rst_c_rdata", c_rdata, 128'(0));
    check("mid_rst_mem_read", 128'(mem_read), 128'(0));
    check("mid_rst_mem_write", 128'(mem_write), 128'(0));
    check("mid_rst_mem_addr", 128'(mem_addr), 128'(0));
    check("mid_rst_mem_wdata", mem_wdata, 128'(0));
    check("mid_rst_hit_cnt", 128'(hit_cnt), 128'(0));
    check("mid_rst_miss_cnt", 128'(miss_cnt), 128'(0));
    check("mid_rst_miss_cnt_sat", 128'(s_miss_cnt), 128'(0));
    proc_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stale_ready_c_ready", 128'(c_ready), 128'(0));
      check("idle_mem_read", 128'(mem_read), 128'(0));
    end
    mdl_valid = 0; mdl_hits = 0; mdl_misses = 0;
    // Line 52 was buffered before the reset; it must now miss.
    do_txn(mk(0, 28'h52, '0, 1, 0, 2, 0, 0, 0), 1'b0, 1'b1);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 250; i++) begin
      v.wr = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 3))
        0, 1:    v.addr = mdl_addr;
        2:       v.addr = 28'h20 + 28'($urandom_range(0, 7));
        default: v.addr = ($urandom_range(0, 1) == 0) ? 28'hFFFFFFF : 28'h0;
      endcase
      v.wdata   = {$urandom, $urandom, $urandom, $urandom};
      v.lat     = int'($urandom_range(0, 4));
      v.settle  = int'($urandom_range(0, 3));
      v.exp_lat = -1;
      v.exp_hit = 0;
      v.chk_pf  = 0;
      v.pf_wait = 0;
      eh = !v.wr && mdl_valid && (mdl_addr == v.addr);
      do_txn(v, eh, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
